// File: rtl/cdc_pkg.sv
// Shared types and limits for the source side of the req/ack clock-domain crossing.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } cdc_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // A timeout of 0 disables the counter, but the counter still needs at least one bit.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt == 0) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_ff.sv
// N-flop bit synchronizer with asynchronous active-high clear.
module cdc_sync_ff
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("cdc_sync_ff: STAGES out of supported range");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_req_sender.sv
// Source-side initiator of a four-phase req/ack handshake carrying one word across domains.
//
//   state  | meaning
//   IDLE   | ready for a word once the synchronized ack is low
//   REQ_HI | req high, word held, waiting for ack rise (optionally bounded)
//   REQ_LO | req low, waiting for ack to return to zero
module cdc_req_sender
  import cdc_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              src_clk,
  input  logic              rst,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int              CNT_W      = cnt_width(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic ack_s;

  cdc_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(src_clk),
    .rst(rst),
    .d  (ack),
    .q  (ack_s)
  );

  cdc_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              accept;

  assign send_ready = (state_q == IDLE) && !ack_s;
  assign accept     = send_valid && send_ready;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    xfer_data_d   = xfer_data_q;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    abort_d       = abort_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          xfer_data_d = send_data;
          req_d       = 1'b1;
          cnt_d       = '0;
          state_d     = REQ_HI;
        end
      end
      REQ_HI: begin
        // ack has priority so a late-but-valid acknowledge is never reported as a timeout
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          req_d         = 1'b0;
          timeout_err_d = 1'b1;
          abort_d       = 1'b1;
          state_d       = REQ_LO;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          done_d  = !abort_q;
          abort_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      xfer_data_q   <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      xfer_data_q   <= xfer_data_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
    end
  end

  assign req         = req_q;
  assign xfer_data   = xfer_data_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_req_sender.sv
// Directed plus randomized bench for cdc_req_sender; the bench plays the destination side.
module tb_cdc_req_sender;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int T  = 8;

  logic          src_clk = 1'b0;
  logic          rst;
  logic          send_valid;
  logic [DW-1:0] send_data;
  logic          send_ready;
  logic          req;
  logic [DW-1:0] xfer_data;
  logic          ack;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int n_assert = 0;
  int fails    = 0;

  cdc_req_sender #(
    .DATA_W        (DW),
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .src_clk    (src_clk),
    .rst        (rst),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .req        (req),
    .xfer_data  (xfer_data),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 src_clk = ~src_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge src_clk);
    #1;
  endtask

  // One transfer, timed from the accept edge (rel 0). The destination raises ack just after
  // edge k_up (k_up<0: never) and drops it m_dn edges after req falls. Expected edges:
  //   ack first sampled at k_up+1, so req falls at k_up+1+S unless the timeout edge T comes
  //   first (a tie goes to ack); idle is reached S edges after ack is first sampled low.
  task automatic run_xfer(input logic [DW-1:0] data, input int k_up, input int m_dn,
                          input bit keep_valid);
    bit normal;
    int f_rel;
    int i_rel;
    normal = (k_up >= 0) && (k_up + 1 + S <= T);
    f_rel  = normal ? (k_up + 1 + S) : T;
    i_rel  = normal ? (f_rel + m_dn + 1 + S) : (f_rel + 1);
    chk("ready_before_accept", send_ready, 1);
    send_valid = 1'b1;
    send_data  = data;
    step();
    send_valid = keep_valid;
    send_data  = ~data;
    for (int rel = 0; rel <= i_rel; rel++) begin
      if (rel > 0) step();
      chk("req", req, (rel < f_rel));
      chk("busy", busy, (rel < i_rel));
      chk("done", done, (rel == i_rel) && normal);
      chk("timeout_err", timeout_err, (rel == f_rel) && !normal);
      chk("xfer_data", xfer_data, data);
      chk("send_ready", send_ready, (rel == i_rel));
      if (normal && rel == k_up) ack = 1'b1;
      if (normal && rel == f_rel + m_dn) ack = 1'b0;
    end
  endtask

  task automatic idle_cycle(input logic [DW-1:0] held);
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req", req, 0);
    chk("idle_xfer_data", xfer_data, held);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            k;
    int            m;

    send_valid = 1'b0;
    send_data  = '0;
    ack        = 1'b0;
    rst        = 1'b1;
    #2;
    chk("rst_req", req, 0);
    chk("rst_xfer_data", xfer_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_send_ready", send_ready, 1);
    @(posedge src_clk);
    @(posedge src_clk);
    #3 rst = 1'b0;
    step();

    // basic transfer: ack 3 cycles after req rises, drops 3 cycles after req falls
    run_xfer(8'hA5, 3, 3, 1'b0);
    idle_cycle(8'hA5);
    idle_cycle(8'hA5);

    // back-to-back with send_valid held: second accept lands on the done cycle
    run_xfer(8'h01, 2, 1, 1'b1);
    run_xfer(8'h02, 2, 1, 1'b0);
    idle_cycle(8'h02);

    // timeout with ack held low
    run_xfer(8'hC3, -1, 0, 1'b0);
    idle_cycle(8'hC3);

    // tie: ack_s rises exactly when the counter reaches T-1, then one edge too late
    run_xfer(8'h96, T - S - 1, 2, 1'b0);
    idle_cycle(8'h96);
    run_xfer(8'h69, -1, 0, 1'b0);
    idle_cycle(8'h69);

    // spurious ack while idle blocks acceptance until ack_s returns low
    ack = 1'b1;
    repeat (S) step();
    send_valid = 1'b1;
    send_data  = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      chk("spur_ready", send_ready, 0);
      chk("spur_req", req, 0);
      chk("spur_busy", busy, 0);
      step();
    end
    ack = 1'b0;
    for (int j = 1; j < S; j++) begin
      step();
      chk("spur_ready_tail", send_ready, 0);
      chk("spur_req_tail", req, 0);
    end
    step();
    run_xfer(8'h3C, 1, 1, 1'b0);
    idle_cycle(8'h3C);

    // reset in the middle of REQ_HI
    send_valid = 1'b1;
    send_data  = 8'hE7;
    step();
    send_valid = 1'b0;
    step();
    chk("mid_req", req, 1);
    chk("mid_busy", busy, 1);
    chk("mid_xfer_data", xfer_data, 8'hE7);
    #2 rst = 1'b1;
    #1;
    chk("mrst_req", req, 0);
    chk("mrst_xfer_data", xfer_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_timeout_err", timeout_err, 0);
    @(posedge src_clk);
    #3 rst = 1'b0;
    step();
    chk("post_rst_ready", send_ready, 1);
    run_xfer(8'h5A, 3, 2, 1'b0);
    idle_cycle(8'h5A);

    // randomized transfers, with and without idle gaps between them
    d = 8'h5A;
    for (int n = 0; n < 25; n++) begin
      d = DW'($urandom);
      k = int'($urandom_range(0, 9));
      if (k + 1 + S > T) k = -1;
      m = int'($urandom_range(0, 4));
      run_xfer(d, k, m, 1'b0);
      repeat ($urandom_range(0, 2)) idle_cycle(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
    $finish;
  end

endmodule
